// File: rtl/bitmap_encoder_pkg.sv
// Shared types and helpers for the bitmap encoder: FSM state and the
// "at most one line active" test used to flag the final beat of a vector.
package bitmap_encoder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Widest line vector the helper accepts; callers zero-extend to this width.
  localparam int MAX_LINES = 1024;

  function automatic logic at_most_one(input logic [MAX_LINES-1:0] vec);
    return (vec & (vec - MAX_LINES'(1))) == '0;
  endfunction

endpackage

// File: rtl/bitmap_encoder_priority_encoder.sv
// Combinational lowest-set-bit encoder; idx is 0 when no bit is set.
module priority_encoder #(
  parameter int IN_WIDTH = 5
) (
  input  logic [(1<<IN_WIDTH)-1:0] vec,
  output logic [IN_WIDTH-1:0]      idx,
  output logic                     any
);

  localparam int LINES = 1 << IN_WIDTH;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IN_WIDTH'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitmap_encoder.sv
// Serialises a multi-hot line vector into a stream of active-line indices,
// lowest first, with a last flag; an empty vector yields one out_zero beat.
module bitmap_encoder
  import bitmap_encoder_pkg::*;
#(
  parameter int IN_WIDTH = 5,
  parameter int ACTIVE   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [(1<<IN_WIDTH)-1:0] in_bits,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [IN_WIDTH-1:0]      out_idx,
  output logic                     out_zero,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int LINES = 1 << IN_WIDTH;

  state_t             state;
  logic [LINES-1:0]   pending;
  logic [IN_WIDTH-1:0] low_idx;
  logic               low_any;
  logic               scan;
  logic               capture;
  logic               beat;

  priority_encoder #(
    .IN_WIDTH(IN_WIDTH)
  ) u_penc (
    .vec(pending),
    .idx(low_idx),
    .any(low_any)
  );

  assign scan      = (state == ST_SCAN);
  assign out_valid = scan;
  assign out_idx   = low_idx;
  assign out_zero  = scan & ~low_any;
  assign out_last  = scan & at_most_one(MAX_LINES'(pending));

  // A new vector may be taken on the final handshake so streams run without a bubble.
  assign in_ready = ~rst & (~scan | (out_ready & out_last));
  assign capture  = in_valid & in_ready;
  assign beat     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else if (capture) begin
      state   <= ST_SCAN;
      pending <= (ACTIVE != 0) ? in_bits : ~in_bits;
    end else if (beat) begin
      pending <= pending & (pending - LINES'(1));
      if (out_last) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_encoder.sv
// Scenario bench for bitmap_encoder (IN_WIDTH=3): expected beats are queued
// when a vector is driven and compared as the encoder hands them over.
module tb_bitmap_encoder;

  typedef struct packed {
    logic [2:0] idx;
    logic       zero;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_bits = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] out_idx;
  logic       out_zero, out_last, out_valid;
  logic       out_ready = 1'b1;

  logic [7:0] lo_bits = 8'hFF;
  logic       lo_valid = 1'b0;
  logic       lo_in_ready;
  logic [2:0] lo_idx;
  logic       lo_zero, lo_last, lo_valid_out;
  logic       lo_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  beat_t q[$];
  beat_t q_lo[$];
  beat_t exp_m, exp_lo;

  bitmap_encoder #(.IN_WIDTH(3), .ACTIVE(1)) dut (
    .clk(clk), .rst(rst), .in_bits(in_bits), .in_valid(in_valid), .in_ready(in_ready),
    .out_idx(out_idx), .out_zero(out_zero), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  bitmap_encoder #(.IN_WIDTH(3), .ACTIVE(0)) dut_lo (
    .clk(clk), .rst(rst), .in_bits(lo_bits), .in_valid(lo_valid), .in_ready(lo_in_ready),
    .out_idx(lo_idx), .out_zero(lo_zero), .out_last(lo_last),
    .out_valid(lo_valid_out), .out_ready(lo_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Scoreboards: every handshaken beat must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got idx=%0d zero=%0b last=%0b, required no beat",
                 out_idx, out_zero, out_last);
      end else begin
        exp_m = q.pop_front();
        if ({out_idx, out_zero, out_last} !== {exp_m.idx, exp_m.zero, exp_m.last}) begin
          errors++;
          $display("FAIL beat: got idx=%0d zero=%0b last=%0b, required idx=%0d zero=%0b last=%0b",
                   out_idx, out_zero, out_last, exp_m.idx, exp_m.zero, exp_m.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && lo_valid_out && lo_ready) begin
      checks++;
      if (q_lo.size() == 0) begin
        errors++;
        $display("FAIL lo_beat_unexpected: got idx=%0d zero=%0b last=%0b, required no beat",
                 lo_idx, lo_zero, lo_last);
      end else begin
        exp_lo = q_lo.pop_front();
        if ({lo_idx, lo_zero, lo_last} !== {exp_lo.idx, exp_lo.zero, exp_lo.last}) begin
          errors++;
          $display("FAIL lo_beat: got idx=%0d zero=%0b last=%0b, required idx=%0d zero=%0b last=%0b",
                   lo_idx, lo_zero, lo_last, exp_lo.idx, exp_lo.zero, exp_lo.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector until it is taken; returns in the cycle after capture.
  task automatic capture(input logic [7:0] v);
    logic ok;
    ok = 1'b0;
    in_bits  = v;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    in_valid = 1'b0;
    in_bits  = 8'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: in_ready=%0b, required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b, required 0", in_ready); end
    if (out_idx !== 3'd0) begin errors++; $display("FAIL rst_out_idx: got %0d, required 0", out_idx); end
    if (out_zero !== 1'b0) begin errors++; $display("FAIL rst_out_zero: got %0b, required 0", out_zero); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b, required 0", out_last); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b, required 1", in_ready); end
    step();
  endtask

  task automatic test_sparse();
    out_ready = 1'b1;
    q.push_back('{3'd2, 1'b0, 1'b0});
    q.push_back('{3'd5, 1'b0, 1'b0});
    q.push_back('{3'd7, 1'b0, 1'b1});
    capture(8'b1010_0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sparse_valid%0d: got %0b, required 1", i, out_valid); end
      if (i == 2) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL sparse_ready_last: got %0b, required 1", in_ready); end
      end
      step();
    end
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sparse_done_valid: got %0b, required 0", out_valid); end
    if (q.size() != 0) begin errors++; $display("FAIL sparse_remaining: got %0d beats left, required 0", q.size()); end
    step();
  endtask

  task automatic test_zero();
    q.push_back('{3'd0, 1'b1, 1'b1});
    capture(8'h00);
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %0b, required 1", out_valid); end
    if (out_zero !== 1'b1) begin errors++; $display("FAIL zero_flag: got %0b, required 1", out_zero); end
    step();
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_done_valid: got %0b, required 0", out_valid); end
    if (q.size() != 0) begin errors++; $display("FAIL zero_remaining: got %0d beats left, required 0", q.size()); end
    step();
  endtask

  task automatic test_full_backpressure();
    int         hs;
    logic       held;
    logic [2:0] hidx;
    logic       hlast;
    hs = 0;
    held = 1'b0;
    hidx = '0;
    hlast = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back('{3'(i), 1'b0, (i == 7)});
    capture(8'hFF);
    for (int c = 0; c < 40 && hs < 8; c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== hidx || out_last !== hlast) begin
          errors++;
          $display("FAIL full_stall_hold: got valid=%0b idx=%0d last=%0b, required valid=1 idx=%0d last=%0b",
                   out_valid, out_idx, out_last, hidx, hlast);
        end
      end
      held = 1'b0;
      if (out_valid && out_ready) hs++;
      else if (out_valid) begin
        held  = 1'b1;
        hidx  = out_idx;
        hlast = out_last;
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks += 3;
    if (hs != 8) begin errors++; $display("FAIL full_handshakes: got %0d, required 8", hs); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_done_valid: got %0b, required 0", out_valid); end
    if (q.size() != 0) begin errors++; $display("FAIL full_remaining: got %0d beats left, required 0", q.size()); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    q.push_back('{3'd0, 1'b0, 1'b1});
    q.push_back('{3'd7, 1'b0, 1'b1});
    in_bits  = 8'h01;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %0b, required 1", in_ready); end
    step();
    in_bits = 8'h80;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %0b, required 1", out_valid); end
    if (out_idx !== 3'd0) begin errors++; $display("FAIL b2b_first_idx: got %0d, required 0", out_idx); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_on_last: got %0b, required 1", in_ready); end
    step();
    in_valid = 1'b0;
    in_bits  = 8'h3C;
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble: got valid=%0b, required 1", out_valid); end
    if (out_idx !== 3'd7) begin errors++; $display("FAIL b2b_second_idx: got %0d, required 7", out_idx); end
    step();
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_valid: got %0b, required 0", out_valid); end
    if (q.size() != 0) begin errors++; $display("FAIL b2b_remaining: got %0d beats left, required 0", q.size()); end
    step();
  endtask

  task automatic test_active_low();
    lo_ready = 1'b1;
    q_lo.push_back('{3'd0, 1'b0, 1'b1});
    lo_bits  = 8'b1111_1110;
    lo_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (lo_in_ready !== 1'b1) begin errors++; $display("FAIL lo_ready: got %0b, required 1", lo_in_ready); end
    step();
    lo_valid = 1'b0;
    lo_bits  = 8'h00;
    @(negedge clk);
    checks++;
    if (lo_valid_out !== 1'b1) begin errors++; $display("FAIL lo_valid: got %0b, required 1", lo_valid_out); end
    step();
    @(negedge clk);
    checks += 2;
    if (lo_valid_out !== 1'b0) begin errors++; $display("FAIL lo_done_valid: got %0b, required 0", lo_valid_out); end
    if (q_lo.size() != 0) begin errors++; $display("FAIL lo_remaining: got %0d beats left, required 0", q_lo.size()); end
    step();
  endtask

  task automatic test_reset_mid_scan();
    out_ready = 1'b1;
    q.push_back('{3'd4, 1'b0, 1'b0});
    capture(8'hF0);
    @(negedge clk);
    checks++;
    if (out_idx !== 3'd4) begin errors++; $display("FAIL mid_first_idx: got %0d, required 4", out_idx); end
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_rst_valid%0d: got %0b, required 0", i, out_valid); end
      step();
    end
    q.push_back('{3'd1, 1'b0, 1'b1});
    capture(8'h02);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid: got %0b, required 1", out_valid); end
    step();
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_new_done: got %0b, required 0", out_valid); end
    if (q.size() != 0) begin errors++; $display("FAIL mid_remaining: got %0d beats left, required 0", q.size()); end
    step();
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_zero();
    test_full_backpressure();
    test_back_to_back();
    test_active_low();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
